alu_result_sink: RTL and testbench

// - Downstream stage of the registered signed add/multiply ALU: captures result/ov/uv each valid cycle.
// - Optionally clamps flagged results to signed full-scale, then queues {flags,data} in a DEPTH-entry FIFO.
// - Drains to the consumer over a valid/ready handshake; reports drops.

---
 rtl/alu_result_sink.sv | 123 ++++++++++++
 tb/tb_alu_result_sink.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sink.sv
// Result sink behind the signed add/multiply ALU: optional clamp, DEPTH-entry FIFO, drop counter.
// Define ALU_SINK_STATS_EN to enable the ov_cnt/uv_cnt statistics counters (tied to 0 otherwise).
module alu_result_sink #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N-1:0]               in_result,
  input  logic                       in_ov,
  input  logic                       in_uv,
  input  logic                       sat_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_ov,
  output logic                       out_uv,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           ov_cnt,
  output logic [CNT_W-1:0]           uv_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [N-1:0]     POS_FS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]     NEG_FS = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry layout: {ov, uv, data}; flags are the ALU's original flags, not post-clamp.
  logic [N+1:0]    mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg, level_next;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [N-1:0]  clamp_data;
  logic [N+1:0]  head;

  assign full = (level_reg == LW'(DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    clamp_data = in_result;
    if (sat_en && in_ov) begin
      clamp_data = POS_FS;
    end else if (sat_en && in_uv) begin
      clamp_data = NEG_FS;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst_n && push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= {in_ov, in_uv, clamp_data};
        end
      end
    end
  endgenerate

  assign level_next = level_reg + LW'(push) - LW'(pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != CNT_MAX)) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

`ifdef ALU_SINK_STATS_EN
  logic [CNT_W-1:0] ov_cnt_reg, uv_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      ov_cnt_reg <= '0;
      uv_cnt_reg <= '0;
    end else begin
      if (push && in_ov && (ov_cnt_reg != CNT_MAX)) ov_cnt_reg <= ov_cnt_reg + 1'b1;
      if (push && in_uv && (uv_cnt_reg != CNT_MAX)) uv_cnt_reg <= uv_cnt_reg + 1'b1;
    end
  end

  assign ov_cnt = ov_cnt_reg;
  assign uv_cnt = uv_cnt_reg;
`else
  assign ov_cnt = '0;
  assign uv_cnt = '0;
`endif

  // Head outputs are forced to zero when empty so stale entries never leak out.
  assign head      = mem_reg[rd_ptr_reg];
  assign out_valid = (level_reg != '0);
  assign out_data  = out_valid ? head[N-1:0] : '0;
  assign out_uv    = out_valid & head[N];
  assign out_ov    = out_valid & head[N+1];
  assign level     = level_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed bench for alu_result_sink: vector table plus hand-written FIFO corner sequences.
module tb_alu_result_sink;

  localparam int N = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  in_result;
  logic          in_ov, in_uv, sat_en;
  logic          out_valid, out_ready;
  logic [N-1:0]  out_data;
  logic          out_ov, out_uv;
  logic [2:0]    level;
  logic [CNT_W-1:0] drop_cnt, ov_cnt, uv_cnt;
  logic          stat_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_result_sink #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
    .in_ov(in_ov), .in_uv(in_uv), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ov(out_ov), .out_uv(out_uv),
    .level(level), .drop_cnt(drop_cnt), .stat_clr(stat_clr),
    .ov_cnt(ov_cnt), .uv_cnt(uv_cnt)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ov, uv, sat, rdy;
    logic        ev;
    logic [15:0] ed;
    logic        eov, euv;
    logic [2:0]  elvl;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic ov, input logic uv,
                       input logic sat, input logic rdy);
    in_valid  = v;
    in_result = d;
    in_ov     = ov;
    in_uv     = uv;
    sat_en    = sat;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [15:0] exp_q [4];
  int exp_stat_ov;
  int exp_stat_uv;

  initial begin
    // in: v d ov uv sat rdy | expected after edge: valid data ov uv level
    vecs[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd1};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
    vecs[2] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 3'd1};
    vecs[3] = '{1'b1, 16'h7FFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 3'd2};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 3'd1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};
    vecs[6] = '{1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 3'd1};
    vecs[7] = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 3'd2};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3'd1};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};

    stat_clr = 1'b0;
    do_reset();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_ov_cnt", 32'(ov_cnt), 32'd0);
    check("reset_uv_cnt", 32'(uv_cnt), 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].ov, vecs[i].uv, vecs[i].sat, vecs[i].rdy);
      step();
      $display("vec %0d: in_valid=%0b in=0x%h ov=%0b uv=%0b sat=%0b rdy=%0b -> valid=%0b data=0x%h ov=%0b uv=%0b level=%0d",
               i, vecs[i].v, vecs[i].d, vecs[i].ov, vecs[i].uv, vecs[i].sat, vecs[i].rdy,
               out_valid, out_data, out_ov, out_uv, level);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d_ov", i), 32'(out_ov), 32'(vecs[i].eov));
      check($sformatf("vec%0d_uv", i), 32'(out_uv), 32'(vecs[i].euv));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].elvl));
    end
    check("table_drop", 32'(drop_cnt), 32'd0);

    // Overfill with consumer stalled: two pushes lost, head held stable.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      $display("fill push %0d: level=%0d drop=%0d head=0x%h", i, level, drop_cnt, out_data);
      check("fill_head_stable", 32'(out_data), 32'h0A00);
    end
    check("fill_level", 32'(level), 32'd4);
    check("fill_drop", 32'(drop_cnt), 32'd2);

    // Full with simultaneous push and pop.
    drive(1'b1, 16'h0B00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    $display("full push+pop: level=%0d drop=%0d head=0x%h", level, drop_cnt, out_data);
    check("pp_level", 32'(level), 32'd4);
    check("pp_drop", 32'(drop_cnt), 32'd2);

    exp_q[0] = 16'h0A01; exp_q[1] = 16'h0A02; exp_q[2] = 16'h0A03; exp_q[3] = 16'h0B00;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      $display("drain %0d: valid=%0b data=0x%h", i, out_valid, out_data);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'(exp_q[i]));
      step();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_level", 32'(level), 32'd0);

    // Drop counter saturation: 4 accepted, 256 more drops on top of 2.
    drive(1'b1, 16'h0C00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step();
    $display("saturation: level=%0d drop=%0d", level, drop_cnt);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("drop_sat_level", 32'(level), 32'd4);

    // Clear wins over a same-cycle drop; FIFO untouched.
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    $display("stat_clr: level=%0d drop=%0d", level, drop_cnt);
    check("clr_drop", 32'(drop_cnt), 32'd0);
    check("clr_level", 32'(level), 32'd4);
    check("clr_head", 32'(out_data), 32'h0C00);

    // Statistics: 3 ov + 2 uv accepted pushes with consumer draining.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), i < 3, i >= 3, 1'b0, 1'b1);
      step();
      $display("stat push %0d: valid=%0b data=0x%h ov=%0b uv=%0b", i, out_valid, out_data, out_ov, out_uv);
      check("stat_head", 32'(out_data), 32'h0100 + 32'(i));
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
`ifdef ALU_SINK_STATS_EN
    exp_stat_ov = 3;
    exp_stat_uv = 2;
`else
    exp_stat_ov = 0;
    exp_stat_uv = 0;
`endif
    $display("stats: ov_cnt=%0d uv_cnt=%0d", ov_cnt, uv_cnt);
    check("ov_cnt", 32'(ov_cnt), 32'(exp_stat_ov));
    check("uv_cnt", 32'(uv_cnt), 32'(exp_stat_uv));
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("ov_cnt_clr", 32'(ov_cnt), 32'd0);
    check("uv_cnt_clr", 32'(uv_cnt), 32'd0);

    // Reset mid-stream discards queued entries.
    drive(1'b1, 16'h0D00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("pre_rst_level", 32'(level), 32'd2);
    rst_n = 1'b0;
    step();
    $display("mid-stream reset: valid=%0b level=%0d", out_valid, level);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
